// File: rtl/memory_arbiter.sv
`timescale 1ns/1ps
// Arbitrates the shared block memory between the instruction cache (read-only)
// and the data cache (read/write), one grant at a time, always via IDLE.
//
// state   | meaning
// IDLE    | no grant; memory strobes low, busywaits mirror the requests
// GRANT_D | data cache owns the memory port until its transaction completes
// GRANT_I | instruction cache owns the memory port until its transaction completes
module memory_arbiter #(
  parameter int ADDR_WIDTH  = 28,
  parameter int BLOCK_WIDTH = 128,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   D_MEM_READ,
  input  logic                   D_MEM_WRITE,
  input  logic [ADDR_WIDTH-1:0]  D_MEM_ADDRESS,
  input  logic [BLOCK_WIDTH-1:0] D_MEM_WRITEDATA,
  output logic [BLOCK_WIDTH-1:0] D_MEM_READDATA,
  output logic                   D_MEM_BUSYWAIT,
  input  logic                   I_MEM_READ,
  input  logic [ADDR_WIDTH-1:0]  I_MEM_ADDRESS,
  output logic [BLOCK_WIDTH-1:0] I_MEM_READDATA,
  output logic                   I_MEM_BUSYWAIT,
  output logic                   MEM_READ,
  output logic                   MEM_WRITE,
  output logic [ADDR_WIDTH-1:0]  MEM_ADDRESS,
  output logic [BLOCK_WIDTH-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_WIDTH-1:0] MEM_READDATA,
  input  logic                   MEM_BUSYWAIT
);

  typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_I} state_t;

  state_t                 state_q, state_d;
  logic                   started_q, started_d;
  logic                   last_q, last_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic [BLOCK_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic [BLOCK_WIDTH-1:0] i_rdata_q, i_rdata_d;

  logic d_req, i_req, complete, d_wins;

  assign d_req    = D_MEM_READ | D_MEM_WRITE;
  assign i_req    = I_MEM_READ;
  assign complete = started_q & ~MEM_BUSYWAIT;
  // On a tie, D wins unless round-robin is on and D had the previous grant.
  assign d_wins   = d_req & (~i_req | ~ROUND_ROBIN | ~last_q);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      started_q <= 1'b0;
      last_q    <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      d_rdata_q <= '0;
      i_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      last_q    <= last_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      d_rdata_q <= d_rdata_d;
      i_rdata_q <= i_rdata_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    started_d      = started_q;
    last_d         = last_q;
    rd_d           = rd_q;
    wr_d           = wr_q;
    d_rdata_d      = d_rdata_q;
    i_rdata_d      = i_rdata_q;
    MEM_READ       = 1'b0;
    MEM_WRITE      = 1'b0;
    MEM_ADDRESS    = '0;
    MEM_WRITEDATA  = '0;
    D_MEM_READDATA = d_rdata_q;
    I_MEM_READDATA = i_rdata_q;
    D_MEM_BUSYWAIT = d_req;
    I_MEM_BUSYWAIT = i_req;

    case (state_q)
      IDLE: begin
        if (d_wins) begin
          state_d   = GRANT_D;
          started_d = 1'b0;
          last_d    = 1'b1;
        end else if (i_req) begin
          state_d   = GRANT_I;
          started_d = 1'b0;
          last_d    = 1'b0;
        end
      end

      GRANT_D: begin
        // Once memory has started, the strobes are replayed from the latched copy
        // so a late withdrawal cannot cut the transaction short.
        MEM_READ       = started_q ? rd_q : D_MEM_READ;
        MEM_WRITE      = started_q ? wr_q : D_MEM_WRITE;
        MEM_ADDRESS    = D_MEM_ADDRESS;
        MEM_WRITEDATA  = D_MEM_WRITEDATA;
        D_MEM_READDATA = MEM_READDATA;
        D_MEM_BUSYWAIT = started_q ? ~complete : d_req;
        if (!started_q) begin
          rd_d = D_MEM_READ;
          wr_d = D_MEM_WRITE;
        end
        if (MEM_BUSYWAIT) started_d = 1'b1;
        if (complete) begin
          d_rdata_d = MEM_READDATA;
          state_d   = IDLE;
        end else if (!started_q && !d_req) begin
          state_d = IDLE;
        end
      end

      GRANT_I: begin
        MEM_READ       = started_q ? rd_q : I_MEM_READ;
        MEM_ADDRESS    = I_MEM_ADDRESS;
        I_MEM_READDATA = MEM_READDATA;
        I_MEM_BUSYWAIT = started_q ? ~complete : i_req;
        if (!started_q) begin
          rd_d = I_MEM_READ;
          wr_d = 1'b0;
        end
        if (MEM_BUSYWAIT) started_d = 1'b1;
        if (complete) begin
          i_rdata_d = MEM_READDATA;
          state_d   = IDLE;
        end else if (!started_q && !i_req) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
`timescale 1ns/1ps
// Bench for memory_arbiter: a round-robin instance (0) and a fixed-priority
// instance (1), each with its own behavioural block memory and cache drivers.
module tb_memory_arbiter;
  localparam int AW = 28;
  localparam int BW = 128;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          d_rd [2], d_wr [2], d_bw [2], i_rd [2], i_bw [2];
  logic          mem_read [2], mem_write [2], mem_busy [2];
  logic [AW-1:0] d_addr [2], i_addr [2], mem_addr [2];
  logic [BW-1:0] d_wdata [2], d_rdata [2], i_rdata [2], mem_wdata [2], mem_rdata [2];

  memory_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .ROUND_ROBIN(1'b1)) dut (
    .CLK(clk), .RESET(rst),
    .D_MEM_READ(d_rd[0]), .D_MEM_WRITE(d_wr[0]), .D_MEM_ADDRESS(d_addr[0]),
    .D_MEM_WRITEDATA(d_wdata[0]), .D_MEM_READDATA(d_rdata[0]), .D_MEM_BUSYWAIT(d_bw[0]),
    .I_MEM_READ(i_rd[0]), .I_MEM_ADDRESS(i_addr[0]), .I_MEM_READDATA(i_rdata[0]),
    .I_MEM_BUSYWAIT(i_bw[0]),
    .MEM_READ(mem_read[0]), .MEM_WRITE(mem_write[0]), .MEM_ADDRESS(mem_addr[0]),
    .MEM_WRITEDATA(mem_wdata[0]), .MEM_READDATA(mem_rdata[0]), .MEM_BUSYWAIT(mem_busy[0])
  );

  memory_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW), .ROUND_ROBIN(1'b0)) dut_rr0 (
    .CLK(clk), .RESET(rst),
    .D_MEM_READ(d_rd[1]), .D_MEM_WRITE(d_wr[1]), .D_MEM_ADDRESS(d_addr[1]),
    .D_MEM_WRITEDATA(d_wdata[1]), .D_MEM_READDATA(d_rdata[1]), .D_MEM_BUSYWAIT(d_bw[1]),
    .I_MEM_READ(i_rd[1]), .I_MEM_ADDRESS(i_addr[1]), .I_MEM_READDATA(i_rdata[1]),
    .I_MEM_BUSYWAIT(i_bw[1]),
    .MEM_READ(mem_read[1]), .MEM_WRITE(mem_write[1]), .MEM_ADDRESS(mem_addr[1]),
    .MEM_WRITEDATA(mem_wdata[1]), .MEM_READDATA(mem_rdata[1]), .MEM_BUSYWAIT(mem_busy[1])
  );

  // Behavioural memory: a strobe starts a 1..3 cycle busy period; the strobe must
  // then drop for at least one cycle before the next transaction is accepted.
  logic [BW-1:0] init_blk [16];
  logic [BW-1:0] mem [2][16];
  logic [BW-1:0] gold [2][16];
  int            busy_cnt [2], done_age [2], mem_starts [2];
  logic          done_hold [2], op_wr [2];
  logic [3:0]    op_addr [2];
  logic [BW-1:0] op_data [2];
  int            gap_err = 0;
  int            cyc_now = 0;

  always @(posedge clk) cyc_now <= cyc_now + 1;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        busy_cnt[k]   <= 0;
        mem_busy[k]   <= 1'b0;
        done_hold[k]  <= 1'b0;
        done_age[k]   <= 0;
        mem_starts[k] <= 0;
        mem_rdata[k]  <= '0;
        for (int j = 0; j < 16; j++) mem[k][j] <= init_blk[j];
      end else if (busy_cnt[k] != 0) begin
        busy_cnt[k] <= busy_cnt[k] - 1;
        if (busy_cnt[k] == 1) begin
          mem_busy[k]  <= 1'b0;
          done_hold[k] <= 1'b1;
          done_age[k]  <= 0;
          if (op_wr[k]) mem[k][op_addr[k]] <= op_data[k];
          else          mem_rdata[k] <= mem[k][op_addr[k]];
        end
      end else if (done_hold[k]) begin
        if (mem_read[k] | mem_write[k]) begin
          if (done_age[k] != 0) gap_err <= gap_err + 1;
          done_age[k] <= done_age[k] + 1;
        end else begin
          done_hold[k] <= 1'b0;
        end
      end else if (mem_read[k] | mem_write[k]) begin
        busy_cnt[k]   <= $urandom_range(3, 1);
        mem_busy[k]   <= 1'b1;
        op_wr[k]      <= mem_write[k];
        op_addr[k]    <= mem_addr[k][3:0];
        op_data[k]    <= mem_wdata[k];
        mem_starts[k] <= mem_starts[k] + 1;
      end
    end
  end

  int    errors = 0;
  int    checks = 0;
  string order_s [2];

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      d_rd[k] = 1'b0; d_wr[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
      i_rd[k] = 1'b0; i_addr[k] = '0;
    end
  endtask

  task automatic do_reset(input bit new_image);
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    if (new_image)
      for (int j = 0; j < 16; j++) init_blk[j] = {$urandom, $urandom, $urandom, $urandom};
    for (int j = 0; j < 16; j++) begin
      gold[0][j] = init_blk[j];
      gold[1][j] = init_blk[j];
    end
    order_s[0] = "";
    order_s[1] = "";
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_d(input int k, input bit wr, input logic [AW-1:0] a,
                        input logic [BW-1:0] wd, output int lat);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (d_bw[k] !== 1'b0 && n < 40);
    lat = n;
    checks++;
    if (d_bw[k] !== 1'b0) begin
      errors++;
      $display("FAIL d_timeout inst=%0d addr=%0h busywait=%b, required 0 within 40 cycles", k, a, d_bw[k]);
    end else begin
      checks++;
      if ((wr ? mem_write[k] : mem_read[k]) !== 1'b1) begin
        errors++;
        $display("FAIL d_strobe_at_completion inst=%0d got rd=%b wr=%b, required strobe still 1", k, mem_read[k], mem_write[k]);
      end
      if (wr) gold[k][a[3:0]] = wd;
      else begin
        checks++;
        if (d_rdata[k] !== gold[k][a[3:0]]) begin
          errors++;
          $display("FAIL d_readdata inst=%0d addr=%0h got %h, required %h", k, a, d_rdata[k], gold[k][a[3:0]]);
        end
      end
      order_s[k] = {order_s[k], "D"};
    end
    d_rd[k] = 1'b0;
    d_wr[k] = 1'b0;
  endtask

  task automatic wait_i(input int k, input logic [AW-1:0] a, output int lat);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (i_bw[k] !== 1'b0 && n < 40);
    lat = n;
    checks++;
    if (i_bw[k] !== 1'b0) begin
      errors++;
      $display("FAIL i_timeout inst=%0d addr=%0h busywait=%b, required 0 within 40 cycles", k, a, i_bw[k]);
    end else begin
      checks++;
      if (mem_read[k] !== 1'b1 || i_rdata[k] !== gold[k][a[3:0]]) begin
        errors++;
        $display("FAIL i_readdata inst=%0d addr=%0h got %h (strobe %b), required %h (strobe 1)", k, a, i_rdata[k], mem_read[k], gold[k][a[3:0]]);
      end
      order_s[k] = {order_s[k], "I"};
    end
    i_rd[k] = 1'b0;
  endtask

  task automatic d_txn(input int k, input bit wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] wd, output int lat);
    d_rd[k] = !wr; d_wr[k] = wr; d_addr[k] = a; d_wdata[k] = wr ? wd : '0;
    wait_d(k, wr, a, wd, lat);
  endtask

  task automatic i_txn(input int k, input logic [AW-1:0] a, output int lat);
    i_rd[k] = 1'b1; i_addr[k] = a;
    wait_i(k, a, lat);
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mem_read[k] !== 1'b0 || mem_write[k] !== 1'b0 || mem_addr[k] !== '0 || mem_wdata[k] !== '0) begin
        errors++;
        $display("FAIL reset_mem inst=%0d got rd=%b wr=%b addr=%h wdata=%h, required all 0", k, mem_read[k], mem_write[k], mem_addr[k], mem_wdata[k]);
      end
      checks++;
      if (d_rdata[k] !== '0 || i_rdata[k] !== '0 || d_bw[k] !== 1'b0 || i_bw[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_cache inst=%0d got drd=%h ird=%h dbw=%b ibw=%b, required all 0", k, d_rdata[k], i_rdata[k], d_bw[k], i_bw[k]);
      end
    end
  endtask

  task automatic test_d_write();
    logic [BW-1:0] wd;
    int n;
    wd = 128'hC0010003_0BADF00D_12345678_9ABCDEF0;
    do_reset(1'b1);
    @(negedge clk);
    d_wr[0] = 1'b1; d_addr[0] = '0; d_wdata[0] = wd;
    #1;
    checks++;
    if (d_bw[0] !== 1'b1 || mem_write[0] !== 1'b0) begin
      errors++;
      $display("FAIL d_stall_same_cycle got bw=%b memwr=%b, required bw=1 memwr=0", d_bw[0], mem_write[0]);
    end
    @(negedge clk);
    checks++;
    if (mem_write[0] !== 1'b1 || mem_addr[0] !== '0 || mem_wdata[0] !== wd) begin
      errors++;
      $display("FAIL d_write_strobe got wr=%b addr=%h data=%h, required 1 0 %h", mem_write[0], mem_addr[0], mem_wdata[0], wd);
    end
    n = 0;
    while (d_bw[0] !== 1'b0 && n < 20) begin
      checks++;
      if (i_bw[0] !== 1'b0 || mem_write[0] !== 1'b1 || mem_read[0] !== 1'b0) begin
        errors++;
        $display("FAIL d_write_hold got ibw=%b wr=%b rd=%b, required 0 1 0", i_bw[0], mem_write[0], mem_read[0]);
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (d_bw[0] !== 1'b0) begin
      errors++;
      $display("FAIL d_write_timeout got bw=%b, required 0", d_bw[0]);
    end
    gold[0][0] = wd;
    d_wr[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_write[0] !== 1'b0 || mem_read[0] !== 1'b0 || d_bw[0] !== 1'b0) begin
      errors++;
      $display("FAIL d_write_release got wr=%b rd=%b bw=%b, required 0 0 0", mem_write[0], mem_read[0], d_bw[0]);
    end
  endtask

  task automatic test_i_read();
    int lat;
    @(negedge clk);
    i_txn(0, '0, lat);
    @(negedge clk);
    checks++;
    if (i_rdata[0] !== gold[0][0] || i_bw[0] !== 1'b0) begin
      errors++;
      $display("FAIL i_readdata_hold got %h bw=%b, required %h bw=0", i_rdata[0], i_bw[0], gold[0][0]);
    end
  endtask

  task automatic test_simultaneous();
    int dl, il, dd, id;
    do_reset(1'b1);
    @(negedge clk);
    d_rd[0] = 1'b1; d_addr[0] = 28'd1;
    i_rd[0] = 1'b1; i_addr[0] = 28'd2;
    fork
      begin wait_d(0, 1'b0, 28'd1, '0, dl); dd = cyc_now; end
      begin wait_i(0, 28'd2, il); id = cyc_now; end
      begin : idle_gap
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (d_bw[0] !== 1'b0 && n < 40);
        @(negedge clk);
        checks++;
        if (mem_read[0] !== 1'b0 || i_bw[0] !== 1'b1) begin
          errors++;
          $display("FAIL sim_idle_gap got memrd=%b ibw=%b, required memrd=0 ibw=1", mem_read[0], i_bw[0]);
        end
      end
    join
    checks++;
    if (order_s[0] != "DI" || id - dd < 3) begin
      errors++;
      $display("FAIL sim_order got %s gap=%0d, required DI gap>=3", order_s[0], id - dd);
    end
  endtask

  task automatic test_round_robin();
    int l;
    do_reset(1'b0);
    @(negedge clk);
    fork
      begin
        d_txn(0, 1'b0, 28'd3, '0, l);
        d_txn(0, 1'b1, 28'd4, {4{32'hA5A5_0001}}, l);
      end
      begin
        i_txn(0, 28'd5, l);
        i_txn(0, 28'd4, l);
      end
    join
    checks++;
    if (order_s[0] != "DIDI") begin
      errors++;
      $display("FAIL rr_order got %s, required DIDI", order_s[0]);
    end
  endtask

  task automatic test_starvation();
    int l;
    do_reset(1'b0);
    @(negedge clk);
    fork
      begin
        d_txn(1, 1'b0, 28'd6, '0, l);
        d_txn(1, 1'b1, 28'd7, {4{32'h5A5A_0002}}, l);
        d_txn(1, 1'b0, 28'd7, '0, l);
      end
      i_txn(1, 28'd7, l);
    join
    checks++;
    if (order_s[1] != "DDDI") begin
      errors++;
      $display("FAIL fixed_priority_order got %s, required DDDI", order_s[1]);
    end
  endtask

  task automatic test_reset_mid();
    int l, n;
    do_reset(1'b1);
    @(negedge clk);
    d_txn(0, 1'b0, 28'd3, '0, l);
    @(negedge clk);
    d_rd[0] = 1'b1; d_addr[0] = 28'd5;
    n = 0;
    do begin @(negedge clk); n++; end while (mem_busy[0] !== 1'b1 && n < 10);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_read[0] !== 1'b0 || mem_write[0] !== 1'b0 || mem_addr[0] !== '0 || mem_wdata[0] !== '0) begin
      errors++;
      $display("FAIL midreset_mem got rd=%b wr=%b addr=%h, required all 0", mem_read[0], mem_write[0], mem_addr[0]);
    end
    checks++;
    if (d_bw[0] !== 1'b1 || i_bw[0] !== 1'b0 || d_rdata[0] !== '0) begin
      errors++;
      $display("FAIL midreset_cache got dbw=%b ibw=%b drd=%h, required 1 0 0", d_bw[0], i_bw[0], d_rdata[0]);
    end
    d_rd[0] = 1'b0;
    #1;
    checks++;
    if (d_bw[0] !== 1'b0) begin
      errors++;
      $display("FAIL midreset_bw_follow got %b, required 0", d_bw[0]);
    end
    rst = 1'b0;
    for (int j = 0; j < 16; j++) gold[0][j] = init_blk[j];
  endtask

  task automatic test_withdraw();
    int l, s0;
    do_reset(1'b1);
    s0 = mem_starts[0];
    @(negedge clk);
    d_rd[0] = 1'b1; d_addr[0] = 28'd7;
    i_rd[0] = 1'b1; i_addr[0] = 28'd9;
    @(negedge clk);
    checks++;
    if (mem_read[0] !== 1'b1 || mem_addr[0] !== 28'd7) begin
      errors++;
      $display("FAIL withdraw_grant got rd=%b addr=%h, required 1 7", mem_read[0], mem_addr[0]);
    end
    d_rd[0] = 1'b0;
    #1;
    checks++;
    if (d_bw[0] !== 1'b0 || mem_read[0] !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_release got dbw=%b rd=%b, required 0 0", d_bw[0], mem_read[0]);
    end
    wait_i(0, 28'd9, l);
    checks++;
    if (mem_starts[0] - s0 !== 1 || d_rdata[0] !== '0 || order_s[0] != "I") begin
      errors++;
      $display("FAIL withdraw_effect got starts=%0d drd=%h order=%s, required 1 0 I", mem_starts[0] - s0, d_rdata[0], order_s[0]);
    end
  endtask

  task automatic test_random();
    int s0;
    do_reset(1'b1);
    s0 = mem_starts[0];
    @(negedge clk);
    fork
      begin
        int l;
        for (int t = 0; t < 25; t++) begin
          repeat ($urandom_range(3, 0)) @(negedge clk);
          d_txn(0, 1'($urandom_range(1, 0)), AW'($urandom_range(15, 0)),
                {$urandom, $urandom, $urandom, $urandom}, l);
          checks++;
          if (l > 14) begin
            errors++;
            $display("FAIL rand_d_latency got %0d cycles, required <= 14", l);
          end
        end
      end
      begin
        int l;
        for (int t = 0; t < 25; t++) begin
          repeat ($urandom_range(3, 0)) @(negedge clk);
          i_txn(0, AW'($urandom_range(15, 0)), l);
          checks++;
          if (l > 14) begin
            errors++;
            $display("FAIL rand_i_latency got %0d cycles, required <= 14", l);
          end
        end
      end
    join
    @(negedge clk);
    checks++;
    if (mem_starts[0] - s0 !== 50) begin
      errors++;
      $display("FAIL rand_txn_count got %0d memory transactions, required 50", mem_starts[0] - s0);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    for (int j = 0; j < 16; j++) init_blk[j] = '0;
    test_reset();
    test_d_write();
    test_i_read();
    test_simultaneous();
    test_round_robin();
    test_starvation();
    test_reset_mid();
    test_withdraw();
    test_random();
    checks++;
    if (gap_err !== 0) begin
      errors++;
      $display("FAIL idle_between_grants got %0d strobe-without-idle events, required 0", gap_err);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
